// File: rtl/memory_rw_if.sv
// Bus between the Simplez control unit and the program/data memory.
// The control unit is the master; the memory is the slave.
interface memory_rw_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              read_enable;
  logic              write_enable;
  logic              clear;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;

  modport master (
    output address, data_in, read_enable, write_enable, clear,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  address, data_in, read_enable, write_enable, clear,
    output data_out, rd_valid, busy
  );
endinterface

// File: rtl/memory_rw.sv
// Simplez program/data RAM with registered read, read-valid flag and a clear sequencer.
// Define MEM_WR_FORWARD_EN for write-first same-cycle read/write (default is read-first).
module memory_rw #(
  parameter int                DATA_W      = 12,
  parameter int                ADDR_W      = 9,
  parameter int                DEPTH       = 512,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(12'o7000)
) (
  input logic        clk,
  input logic        rst,
  memory_rw_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;

  logic              busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_accept;
  logic              wr_accept;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_range = (32'(bus.address) < 32'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The terminal count is DEPTH-1, so the pointer never has to wrap even when DEPTH == 2**ADDR_W.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == LAST_PTR) begin
          state_next = READY;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      READY: begin
        if (bus.clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
    endcase
  end

  // A clear request outranks any read or write presented in the same cycle.
  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    rd_accept = 1'b0;
    wr_accept = 1'b0;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = CLEAR_VALUE;
      end
      READY: begin
        rd_accept = bus.read_enable && !bus.clear;
        wr_accept = bus.write_enable && !bus.clear && in_range;
        mem_we    = wr_accept;
        mem_waddr = bus.address;
        mem_wdata = bus.data_in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_range) begin
`ifdef MEM_WR_FORWARD_EN
      rd_word = wr_accept ? bus.data_in : mem[bus.address[IDX_W-1:0]];
`else
      rd_word = mem[bus.address[IDX_W-1:0]];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        data_out_q <= rd_word;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
